// File: rtl/wb_pipe_pkg.sv
//==============================================================================
// Package : wb_pkg
// Brief   : Shared source-select encoding, buffer entry layout and result mux
//           for the writeback stage.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package wb_pkg;

    // Entry field widths; wb_pipe's XLEN/RADDR_W must match these.
    localparam int c_WB_XLEN    = 32;
    localparam int c_WB_RADDR_W = 5;

    localparam logic [1:0] c_SEL_ALU  = 2'd0;
    localparam logic [1:0] c_SEL_MEM  = 2'd1;
    localparam logic [1:0] c_SEL_PC4  = 2'd2;
    localparam logic [1:0] c_SEL_RSVD = 2'd3;

    typedef struct packed {
        logic [c_WB_RADDR_W-1:0] rd;
        logic                    regwrite;
        logic [c_WB_XLEN-1:0]    data;
    } wb_entry_t;

    // Reserved encoding falls back to the ALU result.
    function automatic logic [c_WB_XLEN-1:0] wb_select(
        input logic [1:0]           sel,
        input logic [c_WB_XLEN-1:0] alu,
        input logic [c_WB_XLEN-1:0] mem,
        input logic [c_WB_XLEN-1:0] pc4
    );
        logic [c_WB_XLEN-1:0] result;
        case (sel)
            c_SEL_MEM: result = mem;
            c_SEL_PC4: result = pc4;
            default:   result = alu;
        endcase
        return result;
    endfunction

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_pipe_fifo.sv
//==============================================================================
// Module : wb_fifo
// Brief  : DEPTH-entry synchronous FIFO of writeback entries with flush.
//          WB_PIPE_FWD_EN additionally exposes storage and read state.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  wb_entry_t                i_entry,
    output wb_entry_t                o_head,
    output logic                     o_full,
    output logic                     o_empty
`ifdef WB_PIPE_FWD_EN
    ,
    output wb_entry_t                o_mem [DEPTH],
    output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
    output logic [$clog2(DEPTH):0]   o_count
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

`ifdef WB_PIPE_FWD_EN
    assign o_mem    = r_mem;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
`endif

endmodule : wb_fifo

`default_nettype wire

// File: rtl/wb_pipe.sv
//==============================================================================
// Module : wb_pipe
// Brief  : Buffered writeback stage: resolves the result source, queues
//          entries and drains them into the register-file write port.
//          Define WB_PIPE_FWD_EN to add the youngest-entry forwarding ports.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module wb_pipe
    import wb_pkg::*;
#(
    parameter int XLEN    = c_WB_XLEN,
    parameter int RADDR_W = c_WB_RADDR_W,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 32
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]    in_alu,
    input  logic [XLEN-1:0]    in_mem,
    input  logic [XLEN-1:0]    in_pc4,
    input  logic [1:0]         in_sel,
    input  logic               in_regwrite,
    input  logic               flush,
    input  logic               rf_ready,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               retire,
    output logic [CNT_W-1:0]   retire_cnt
`ifdef WB_PIPE_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_data
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_entry_t        w_enq_entry;
    wb_entry_t        w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_retire;
    logic             w_head_exempt;

    logic             r_retire;
    logic [CNT_W-1:0] r_retire_cnt;

    always_comb begin
        w_enq_entry          = '0;
        w_enq_entry.rd       = in_rd;
        w_enq_entry.regwrite = in_regwrite;
        w_enq_entry.data     = wb_select(in_sel, in_alu, in_mem, in_pc4);
    end

    // Readiness depends only on occupancy, never on this cycle's retirement.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full && !flush;

    // x0 writes and non-writing entries drain without the write port.
    assign w_head_exempt = !w_head.regwrite || (w_head.rd == '0);
    assign w_retire      = !w_empty && !flush && (rf_ready || w_head_exempt);

    assign rf_we    = !w_empty && !flush && rf_ready && !w_head_exempt;
    assign rf_waddr = w_empty ? '0 : w_head.rd;
    assign rf_wdata = w_empty ? '0 : w_head.data;

`ifdef WB_PIPE_FWD_EN
    wb_entry_t          w_mem [DEPTH];
    logic [c_PTR_W-1:0] w_rd_ptr;
    logic [c_CNT_W-1:0] w_count;
`endif

    wb_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push),
        .i_pop    (w_retire),
        .i_flush  (flush),
        .i_entry  (w_enq_entry),
        .o_head   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
`ifdef WB_PIPE_FWD_EN
        ,
        .o_mem    (w_mem),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire     <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_retire <= w_retire;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign retire     = r_retire;
    assign retire_cnt = r_retire_cnt;

`ifdef WB_PIPE_FWD_EN
    // Walk oldest to youngest so the last qualifying slot wins.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((c_CNT_W'(k) < w_count) &&
                w_mem[w_rd_ptr + c_PTR_W'(k)].regwrite &&
                (w_mem[w_rd_ptr + c_PTR_W'(k)].rd != '0)) begin
                fwd_valid = 1'b1;
                fwd_rd    = w_mem[w_rd_ptr + c_PTR_W'(k)].rd;
                fwd_data  = w_mem[w_rd_ptr + c_PTR_W'(k)].data;
            end
        end
        if (flush) begin
            fwd_valid = 1'b0;
            fwd_rd    = '0;
            fwd_data  = '0;
        end
    end
`endif

endmodule : wb_pipe

`default_nettype wire

// File: tb/tb_wb_pipe.sv
//==============================================================================
// Module : tb_wb_pipe
// Brief  : Self-checking bench for wb_pipe (DEPTH=2, CNT_W=4); covers the
//          forwarding ports when WB_PIPE_FWD_EN is defined.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_wb_pipe;
    import wb_pkg::*;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [RADDR_W-1:0] in_rd;
    logic [XLEN-1:0]    in_alu;
    logic [XLEN-1:0]    in_mem;
    logic [XLEN-1:0]    in_pc4;
    logic [1:0]         in_sel;
    logic               in_regwrite;
    logic               flush;
    logic               rf_ready;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]    rf_wdata;
    logic               retire;
    logic [CNT_W-1:0]   retire_cnt;
`ifdef WB_PIPE_FWD_EN
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]    fwd_data;
`endif

    wb_pipe #(
        .XLEN        (XLEN),
        .RADDR_W     (RADDR_W),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_alu      (in_alu),
        .in_mem      (in_mem),
        .in_pc4      (in_pc4),
        .in_sel      (in_sel),
        .in_regwrite (in_regwrite),
        .flush       (flush),
        .rf_ready    (rf_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .retire      (retire),
        .retire_cnt  (retire_cnt)
`ifdef WB_PIPE_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]         sel;
        logic [RADDR_W-1:0] rd;
        logic               rw;
        logic               rfr;
        logic [XLEN-1:0]    alu;
        logic [XLEN-1:0]    mem;
        logic [XLEN-1:0]    pc4;
        logic               exp_we;
        logic [XLEN-1:0]    exp_data;
    } vec_t;

    typedef struct {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
    } wr_t;

    vec_t       vecs [7];
    wr_t        sb [$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [RADDR_W-1:0] rd, input logic rw,
                         input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
                         input logic [XLEN-1:0] pc4);
        in_valid    = 1'b1;
        in_sel      = sel;
        in_rd       = rd;
        in_regwrite = rw;
        in_alu      = alu;
        in_mem      = mem;
        in_pc4      = pc4;
    endtask

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected rf_we", {27'd0, rf_waddr}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("sb rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
                check("sb rf_wdata", rf_wdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{c_SEL_MEM,  5'd5,  1'b1, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{c_SEL_ALU,  5'd7,  1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'h1234_5678};
        vecs[2] = '{c_SEL_PC4,  5'd31, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0104, 1'b1, 32'h0000_0104};
        vecs[3] = '{c_SEL_RSVD, 5'd1,  1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0010, 1'b1, 32'hA5A5_A5A5};
        vecs[4] = '{c_SEL_MEM,  5'd0,  1'b1, 1'b0, 32'h0000_0003, 32'hCAFE_F00D, 32'h0000_0020, 1'b0, 32'hCAFE_F00D};
        vecs[5] = '{c_SEL_ALU,  5'd9,  1'b0, 1'b0, 32'h0BAD_F00D, 32'h0000_0004, 32'h0000_0030, 1'b0, 32'h0BAD_F00D};
        vecs[6] = '{c_SEL_PC4,  5'd12, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0006, 32'h0000_0ABC, 1'b1, 32'h0000_0ABC};

        in_valid = 1'b0; in_sel = '0; in_rd = '0; in_regwrite = 1'b0;
        in_alu = '0; in_mem = '0; in_pc4 = '0; flush = 1'b0; rf_ready = 1'b0;
        exp_cnt = 4'd0;
        reset = 1'b1;

        // Reset state
        next_cycle();
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst rf_we", {31'd0, rf_we}, 32'd0);
        check("rst retire", {31'd0, retire}, 32'd0);
        check("rst retire_cnt", {28'd0, retire_cnt}, 32'd0);
        reset = 1'b0;
        next_cycle();

        // Single-entry vectors: source select, x0 and non-writing entries
        for (int i = 0; i < 7; i++) begin
            rf_ready = vecs[i].rfr;
            drive(vecs[i].sel, vecs[i].rd, vecs[i].rw, vecs[i].alu, vecs[i].mem, vecs[i].pc4);
            if (vecs[i].exp_we) expect_write(vecs[i].rd, vecs[i].exp_data);
            next_cycle();
            in_valid = 1'b0;
            check($sformatf("v%0d rf_we", i), {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("v%0d rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].exp_data);
            check($sformatf("v%0d retire early", i), {31'd0, retire}, 32'd0);
            next_cycle();
            exp_cnt = exp_cnt + 4'd1;
            check($sformatf("v%0d retire", i), {31'd0, retire}, 32'd1);
            check($sformatf("v%0d retire_cnt", i), {28'd0, retire_cnt}, {28'd0, exp_cnt});
            check($sformatf("v%0d drained rf_we", i), {31'd0, rf_we}, 32'd0);
        end

        // Back-pressure: fill with rf_ready low, third entry held until space
        rf_ready = 1'b0;
        drive(c_SEL_ALU, 5'd10, 1'b1, 32'h0000_00AA, '0, '0);
        expect_write(5'd10, 32'h0000_00AA);
        next_cycle();
        check("bp one in_ready", {31'd0, in_ready}, 32'd1);
        drive(c_SEL_ALU, 5'd11, 1'b1, 32'h0000_00BB, '0, '0);
        expect_write(5'd11, 32'h0000_00BB);
        next_cycle();
        check("bp full in_ready", {31'd0, in_ready}, 32'd0);
        drive(c_SEL_ALU, 5'd12, 1'b1, 32'h0000_00CC, '0, '0);
        expect_write(5'd12, 32'h0000_00CC);
        next_cycle();
        check("bp held in_ready", {31'd0, in_ready}, 32'd0);
        check("bp held rf_we", {31'd0, rf_we}, 32'd0);
        check("bp head rf_waddr", {27'd0, rf_waddr}, 32'd10);
        rf_ready = 1'b1;
        next_cycle();
        check("bp after A in_ready", {31'd0, in_ready}, 32'd1);
        check("bp after A head", {27'd0, rf_waddr}, 32'd11);
        next_cycle();
        in_valid = 1'b0;
        check("bp C head", {27'd0, rf_waddr}, 32'd12);
        next_cycle();
        next_cycle();
        exp_cnt = exp_cnt + 4'd3;
        check("bp retire_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});
        check("bp sb drained", sb.size(), 32'd0);

        // Flush with two buffered entries, write port offered in flush cycle
        rf_ready = 1'b0;
        drive(c_SEL_ALU, 5'd4, 1'b1, 32'h0000_0044, '0, '0);
        next_cycle();
        drive(c_SEL_ALU, 5'd6, 1'b1, 32'h0000_0066, '0, '0);
        next_cycle();
        in_valid = 1'b0;
        check("fl full in_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        rf_ready = 1'b1;
        #1;
        check("fl cycle rf_we", {31'd0, rf_we}, 32'd0);
        next_cycle();
        flush = 1'b0;
        check("fl in_ready", {31'd0, in_ready}, 32'd1);
        check("fl empty rf_waddr", {27'd0, rf_waddr}, 32'd0);
        check("fl retire", {31'd0, retire}, 32'd0);
        next_cycle();
        check("fl retire_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});

        // Flush blocks a same-cycle enqueue
        flush = 1'b1;
        drive(c_SEL_MEM, 5'd8, 1'b1, '0, 32'h0000_0088, '0);
        next_cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl enq blocked waddr", {27'd0, rf_waddr}, 32'd0);
        check("fl enq blocked wdata", rf_wdata, 32'd0);
        next_cycle();

        // Streaming enqueue+retire, retire_cnt wraps to zero twice
        n = 16 - int'(exp_cnt);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < n; i++) begin
                drive(c_SEL_ALU, 5'((i % 31) + 1), 1'b1, 32'(i * 32'h111 + pass), '0, '0);
                expect_write(5'((i % 31) + 1), 32'(i * 32'h111 + pass));
                next_cycle();
                check($sformatf("st p%0d i%0d in_ready", pass, i), {31'd0, in_ready}, 32'd1);
            end
            in_valid = 1'b0;
            exp_cnt = exp_cnt + 4'(n);
            next_cycle();
            next_cycle();
            check($sformatf("wrap p%0d retire_cnt", pass), {28'd0, retire_cnt}, {28'd0, exp_cnt});
            check($sformatf("wrap p%0d zero", pass), {28'd0, retire_cnt}, 32'd0);
            n = 16;
        end

`ifdef WB_PIPE_FWD_EN
        // Forwarding shows the youngest qualifying entry
        rf_ready = 1'b0;
        drive(c_SEL_ALU, 5'd3, 1'b1, 32'h0000_0001, '0, '0);
        next_cycle();
        check("fwd1 valid", {31'd0, fwd_valid}, 32'd1);
        check("fwd1 data", fwd_data, 32'h0000_0001);
        drive(c_SEL_ALU, 5'd3, 1'b1, 32'h0000_0002, '0, '0);
        next_cycle();
        in_valid = 1'b0;
        check("fwd2 rd", {27'd0, fwd_rd}, 32'd3);
        check("fwd2 data", fwd_data, 32'h0000_0002);
        flush = 1'b1;
        #1;
        check("fwd flush valid", {31'd0, fwd_valid}, 32'd0);
        next_cycle();
        flush = 1'b0;
        check("fwd empty valid", {31'd0, fwd_valid}, 32'd0);
        drive(c_SEL_ALU, 5'd3, 1'b1, 32'h0000_0007, '0, '0);
        next_cycle();
        drive(c_SEL_ALU, 5'd9, 1'b0, 32'h0000_0009, '0, '0);
        next_cycle();
        in_valid = 1'b0;
        check("fwd skip rd", {27'd0, fwd_rd}, 32'd3);
        check("fwd skip data", fwd_data, 32'h0000_0007);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
`endif

        // Reset mid-operation drops buffered entries without writes
        rf_ready = 1'b0;
        drive(c_SEL_ALU, 5'd13, 1'b1, 32'h0000_0D0D, '0, '0);
        next_cycle();
        drive(c_SEL_ALU, 5'd14, 1'b1, 32'h0000_0E0E, '0, '0);
        next_cycle();
        in_valid = 1'b0;
        reset = 1'b1;
        rf_ready = 1'b1;
        #1;
        check("mid rst rf_we", {31'd0, rf_we}, 32'd0);
        check("mid rst retire_cnt", {28'd0, retire_cnt}, 32'd0);
        check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        check("mid rst rf_waddr", {27'd0, rf_waddr}, 32'd0);
        next_cycle();
        reset = 1'b0;
        exp_cnt = 4'd0;
        next_cycle();
        next_cycle();
        check("post rst retire", {31'd0, retire}, 32'd0);
        check("post rst retire_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});
        check("final sb drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_pipe

`default_nettype wire

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter XLEN, 32, register data width.
REQ-002 Parameter RADDR_W, 5, register-index width.
REQ-003 Parameter DEPTH, 2, writeback buffer entries; power of two, at least 2.
REQ-004 Parameter CNT_W, 32, retire counter width.
REQ-005 Port clk  in  1  sole clock; all state on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port in_valid  in  1  upstream (MEM) result valid.
REQ-008 Port in_ready  out  1  stage can accept this cycle.
REQ-009 Port in_rd  in  RADDR_W  destination register.
REQ-010 Port in_alu / in_mem / in_pc4  in  XLEN each  candidate results.
REQ-011 Port in_sel  in  2  source select: 0 ALU, 1 MEM, 2 PC4, 3 reserved (treated as ALU).
REQ-012 Port in_regwrite  in  1  instruction writes a register.
REQ-013 Port flush  in  1  discard all buffered entries.
REQ-014 Port rf_ready  in  1  register-file write port available.
REQ-015 Port rf_we  out  1; rf_waddr  out  RADDR_W; rf_wdata  out  XLEN  register-file write.
REQ-016 Port retire  out  1  one-cycle pulse per retired entry.
REQ-017 Port retire_cnt  out  CNT_W  total retired entries.

Function
REQ-018 Enqueue SHALL occur when in_valid && in_ready && !flush; data SHALL be resolved by in_sel at enqueue and stored with in_rd and in_regwrite.
REQ-019 in_ready SHALL equal !full, independent of rf_ready (no combinational pass-through).
REQ-020 Minimum latency SHALL be one cycle: entry enqueued at edge N is at the head in cycle N+1.
REQ-021 Head retires when !empty && !flush && (rf_ready || !head.regwrite || head.rd==0).
REQ-022 rf_we SHALL be !empty && !flush && rf_ready && head.regwrite && head.rd!=0; rf_waddr/rf_wdata SHALL show the head entry (zero when empty).
REQ-023 Writes to x0 and non-writing entries SHALL retire without asserting rf_we and without waiting on rf_ready.
REQ-024 Simultaneous enqueue and retire SHALL be allowed when not full; occupancy unchanged.
REQ-025 Full: in_ready low; an enqueue is impossible even if the head retires that cycle.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-027 flush SHALL empty the buffer at the next edge, suppress rf_we and retire in the flush cycle, and block enqueue that cycle.
REQ-028 retire SHALL be registered: high the cycle after a head retirement.
REQ-029 retire_cnt SHALL increment by one per retirement, wrapping at 2^CNT_W.

Reset
REQ-030 reset asserted SHALL immediately clear buffer, pointers, retire, retire_cnt; in_ready SHALL read 1 and rf_we 0 during reset.
REQ-031 Reset asserted mid-operation SHALL drop all buffered entries without register-file writes.

Configuration
REQ-032 Macro WB_PIPE_FWD_EN defined: ports fwd_valid (1), fwd_rd (RADDR_W), fwd_data (XLEN) SHALL expose the youngest buffered entry with regwrite && rd!=0, combinationally; fwd_valid 0 when none or flush.
REQ-033 Macro undefined: forwarding ports and logic SHALL be absent.

Structure
REQ-034 Package wb_pkg SHALL hold the in_sel encoding constants and the buffer entry typedef (rd, regwrite, data).
REQ-035 Storage SHALL be one sub-module wb_fifo (DEPTH-entry synchronous FIFO, async active-high reset).

Verification
REQ-036 Single enqueue rd=5, sel=1, in_mem=0xDEADBEEF, rf_ready=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; retire pulses the following cycle; retire_cnt=1.
REQ-037 rf_ready=0, three back-to-back enqueues, DEPTH=2 -> in_ready low after two; no rf_we; release rf_ready -> in-order writes, then third accepted.
REQ-038 Enqueue rd=0 with regwrite=1 and rf_ready=0 -> retires next cycle with rf_we=0, retire_cnt increments.
REQ-039 Two buffered entries, flush=1 one cycle -> no rf_we, buffer empty, retire_cnt unchanged, in_ready=1.
REQ-040 CNT_W=4, 16 retirements -> retire_cnt returns to 0; reset asserted with entries buffered -> rf_we 0 immediately, retire_cnt 0.
REQ-041 With WB_PIPE_FWD_EN, entries rd=3 (0x1) then rd=3 (0x2) buffered -> fwd_rd=3, fwd_data=0x2.
